// File: rtl/bcd_field_renderer.sv
// bcd_field_renderer: VGA overlay of NUM_FIELDS two-digit BCD fields.
// Frame-synchronous snapshot, 3-stage pixel pipeline, blink highlight.
module bcd_field_renderer #(
  parameter int          NUM_FIELDS   = 3,
  parameter int          X0           = 192,
  parameter int          Y0           = 320,
  parameter int          SCALE_SH     = 2,
  parameter int          FIELD_GAP    = 64,
  parameter logic [11:0] FG_COLOR     = 12'h0FF,
  parameter logic [11:0] SEL_COLOR    = 12'hF00,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_on,
  input  logic                    frame_tick,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic [8*NUM_FIELDS-1:0] fields_bcd,
  input  logic                    edit_on,
  input  logic [2:0]              edit_sel,
  output logic [11:0]             rgb,
  output logic                    in_text
);

  localparam int W  = 8 << SCALE_SH;
  localparam int H  = 16 << SCALE_SH;
  localparam int P  = 2 * W + FIELD_GAP;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] TC   = CW'(BLINK_FRAMES - 1);
  localparam logic [10:0]   Y_LO = 11'(Y0);
  localparam logic [10:0]   Y_HI = 11'(Y0 + H - 1);

  typedef enum logic {
    B_OFF = 1'b0,
    B_ON  = 1'b1
  } blink_t;

  blink_t          blink_q, blink_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic [2:0]      sel_q;
  logic [7:0]      snap [NUM_FIELDS];

  // Segment-built glyphs: {a,b,c,d,e,f,g}, rows 0 and 15 stay blank.
  function automatic logic [7:0] font_row(
    input logic [3:0] d,
    input logic [3:0] r
  );
    logic [6:0] sg;
    logic [7:0] fr;
    sg = 7'h00;
    fr = 8'h00;
    case (d)
      4'd0: sg = 7'h7E;
      4'd1: sg = 7'h30;
      4'd2: sg = 7'h6D;
      4'd3: sg = 7'h79;
      4'd4: sg = 7'h33;
      4'd5: sg = 7'h5B;
      4'd6: sg = 7'h5F;
      4'd7: sg = 7'h70;
      4'd8: sg = 7'h7F;
      4'd9: sg = 7'h7B;
      default: sg = 7'h00;
    endcase
    unique case (1'b1)
      (r == 4'd1 || r == 4'd2):
        fr = sg[6] ? 8'h7E : 8'h00;
      (r >= 4'd3 && r <= 4'd6):
        fr = (sg[1] ? 8'h60 : 8'h00)
           | (sg[5] ? 8'h06 : 8'h00);
      (r == 4'd7 || r == 4'd8):
        fr = sg[0] ? 8'h7E : 8'h00;
      (r >= 4'd9 && r <= 4'd12):
        fr = (sg[2] ? 8'h60 : 8'h00)
           | (sg[4] ? 8'h06 : 8'h00);
      (r == 4'd13 || r == 4'd14):
        fr = sg[3] ? 8'h7E : 8'h00;
      default:
        fr = 8'h00;
    endcase
    return fr;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FIELDS; k++)
        snap[k] <= 8'h00;
    end else if (frame_tick) begin
      for (int k = 0; k < NUM_FIELDS; k++)
        snap[k] <= fields_bcd[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= B_ON;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
    end else begin
      blink_q <= blink_nx;
      cnt_q   <= cnt_nx;
      sel_q   <= edit_sel;
    end
  end

  // Leaving edit mode or moving the selection restarts a full ON phase.
  always_comb begin
    blink_nx = blink_q;
    cnt_nx   = cnt_q;
    if (!edit_on || edit_sel != sel_q) begin
      blink_nx = B_ON;
      cnt_nx   = '0;
    end else if (frame_tick) begin
      if (cnt_q == TC) begin
        cnt_nx   = '0;
        blink_nx = (blink_q == B_ON) ? B_OFF : B_ON;
      end else begin
        cnt_nx = cnt_q + CW'(1);
      end
    end
  end

  logic [10:0] px, py, left, dx, dy;
  logic        hit, sel_hit;
  logic [7:0]  byte_k;
  logic [3:0]  nib_d;
  logic [11:0] color_d;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  always_comb begin
    hit     = 1'b0;
    sel_hit = 1'b0;
    left    = '0;
    byte_k  = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (px >= 11'(X0 + k * P) &&
          px <= 11'(X0 + k * P + 2 * W - 1)) begin
        hit     = 1'b1;
        left    = 11'(X0 + k * P);
        byte_k  = snap[k];
        sel_hit = edit_on && (edit_sel == 3'(k));
      end
    end
    hit = hit && (py >= Y_LO) && (py <= Y_HI);
  end

  assign dx    = px - left;
  assign dy    = py - Y_LO;
  assign nib_d = dx[SCALE_SH+3] ? byte_k[3:0] : byte_k[7:4];

  always_comb begin
    color_d = FG_COLOR;
    if (sel_hit)
      color_d = (blink_q == B_ON) ? SEL_COLOR : 12'h000;
  end

  logic        s1_box;
  logic [3:0]  s1_nib, s1_row;
  logic [2:0]  s1_col;
  logic [11:0] s1_color;
  logic        s2_box;
  logic [7:0]  s2_bits;
  logic [2:0]  s2_col;
  logic [11:0] s2_color;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_box   <= 1'b0;
      s1_nib   <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_color <= '0;
    end else begin
      s1_box   <= hit && video_on;
      s1_nib   <= nib_d;
      s1_row   <= dy[SCALE_SH +: 4];
      s1_col   <= dx[SCALE_SH +: 3];
      s1_color <= video_on ? color_d : 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_box   <= 1'b0;
      s2_bits  <= '0;
      s2_col   <= '0;
      s2_color <= '0;
    end else begin
      s2_box   <= s1_box;
      s2_bits  <= font_row(s1_nib, s1_row);
      s2_col   <= s1_col;
      s2_color <= s1_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb     <= '0;
      in_text <= 1'b0;
    end else begin
      rgb     <= (s2_box && s2_bits[3'd7 - s2_col])
               ? s2_color : 12'h000;
      in_text <= s2_box;
    end
  end

endmodule

// File: tb/tb_bcd_field_renderer.sv
// tb_bcd_field_renderer: random + directed bench for bcd_field_renderer.
// Reference model works in pixel geometry; outputs lag inputs by 3 clocks.
module tb_bcd_field_renderer;

  localparam int NF = 3;
  localparam int X0 = 192;
  localparam int Y0 = 320;
  localparam int S  = 4;
  localparam int W  = 32;
  localparam int H  = 64;
  localparam int P  = 128;
  localparam int BF = 30;
  localparam logic [11:0] FG  = 12'h0FF;
  localparam logic [11:0] SEL = 12'hF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b1;
  logic        frame_tick = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [23:0] fields_bcd = '0;
  logic        edit_on = 1'b0;
  logic [2:0]  edit_sel = '0;
  logic [11:0] rgb;
  logic        in_text;

  bcd_field_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .fields_bcd (fields_bcd),
    .edit_on    (edit_on),
    .edit_sel   (edit_sel),
    .rgb        (rgb),
    .in_text    (in_text)
  );

  always #5 clk = ~clk;

  string segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  logic [7:0]  snap_m [NF] = '{default: 8'h00};
  int          bcnt = 0;
  bit          bphase = 1'b1;
  logic [2:0]  psel = '0;
  logic [12:0] q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit has_seg(int d, byte c);
    string s = segs[d];
    for (int i = 0; i < s.len(); i++)
      if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit glyph_on(int d, int row, int col);
    bit top, up, mid, low, bot, hc, lc, rc;
    if (d > 9) return 1'b0;
    top = row >= 1 && row <= 2;
    up  = row >= 3 && row <= 6;
    mid = row >= 7 && row <= 8;
    low = row >= 9 && row <= 12;
    bot = row >= 13 && row <= 14;
    hc  = col >= 1 && col <= 6;
    lc  = col >= 1 && col <= 2;
    rc  = col >= 5 && col <= 6;
    return (top && hc && has_seg(d, "a")) ||
           (mid && hc && has_seg(d, "g")) ||
           (bot && hc && has_seg(d, "d")) ||
           (up  && lc && has_seg(d, "f")) ||
           (up  && rc && has_seg(d, "b")) ||
           (low && lc && has_seg(d, "e")) ||
           (low && rc && has_seg(d, "c"));
  endfunction

  function automatic logic [12:0] model_pix();
    int x = int'(pix_x);
    int y = int'(pix_y);
    if (!video_on) return 13'h0;
    for (int k = 0; k < NF; k++) begin
      int lo = X0 + k * P;
      if (x >= lo && x < lo + 2 * W && y >= Y0 && y < Y0 + H) begin
        int dx  = x - lo;
        int row = (y - Y0) / S;
        int col = (dx % W) / S;
        int nib = (dx / W == 0) ? int'(snap_m[k][7:4])
                                : int'(snap_m[k][3:0]);
        if (!glyph_on(nib, row, col)) return {1'b1, 12'h000};
        if (edit_on && int'(edit_sel) == k)
          return {1'b1, bphase ? SEL : 12'h000};
        return {1'b1, FG};
      end
    end
    return 13'h0;
  endfunction

  task automatic cycle();
    logic [12:0] e;
    e = model_pix();
    q.push_back(e);
    @(posedge clk);
    if (reset) begin
      snap_m = '{default: 8'h00};
      bcnt   = 0;
      bphase = 1'b1;
      psel   = '0;
    end else begin
      if (frame_tick)
        for (int k = 0; k < NF; k++) snap_m[k] = fields_bcd[8*k +: 8];
      if (!edit_on || edit_sel != psel) begin
        bcnt   = 0;
        bphase = 1'b1;
      end else if (frame_tick) begin
        bcnt++;
        if (bcnt == BF) begin
          bcnt   = 0;
          bphase = !bphase;
        end
      end
      psel = edit_sel;
    end
    @(negedge clk);
    if (reset) begin
      q.delete();
      q.push_back(13'h0);
      q.push_back(13'h0);
      chk("reset", {in_text, rgb}, 13'h0);
    end else if (q.size() == 3) begin
      e = q.pop_front();
      chk("pixel", {in_text, rgb}, e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic at(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
  endtask

  task automatic tick_hold();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    run(3);
  endtask

  int bx [7] = '{191, 192, 255, 256, 320, 511, 512};
  bit bxe [7] = '{0, 1, 1, 0, 1, 1, 0};
  int by [3] = '{319, 383, 384};
  bit bye [3] = '{0, 1, 0};

  initial begin
    fields_bcd = 24'h563412;
    at(196, 324);
    run(2);
    reset = 1'b0;
    run(3);
    chk("default_00", {in_text, rgb}, {1'b1, FG});

    at(200, 320);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    at(212, 332);
    run(2);
    chk("lat_early", {in_text, rgb}, {1'b1, 12'h000});
    run(1);
    chk("latency", {in_text, rgb}, {1'b1, FG});
    fields_bcd = 24'h000000;
    run(4);
    chk("no_tick", {in_text, rgb}, {1'b1, FG});

    for (int i = 0; i < 7; i++) begin
      at(bx[i], 330);
      run(3);
      chk("bound_x", {12'h0, in_text}, {12'h0, bxe[i]});
    end
    for (int i = 0; i < 3; i++) begin
      at(200, by[i]);
      run(3);
      chk("bound_y", {12'h0, in_text}, {12'h0, bye[i]});
    end
    at(200, 320);
    run(3);
    chk("row0", {in_text, rgb}, {1'b1, 12'h000});
    at(200, 383);
    run(3);
    chk("row15", {in_text, rgb}, {1'b1, 12'h000});

    fields_bcd = 24'h56A712;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        at(320 + 4 * c + 1, 320 + 4 * r + 2);
        cycle();
      end
    at(356, 324);
    run(3);
    chk("digit7", {in_text, rgb}, {1'b1, FG});

    edit_on  = 1'b1;
    edit_sel = 3'd1;
    run(1);
    for (int t = 1; t <= 90; t++) begin
      tick_hold();
      chk("blink", {in_text, rgb},
          {1'b1, ((t / BF) % 2 == 0) ? SEL : 12'h000});
    end
    at(228, 324);
    run(3);
    chk("field0_fg", {in_text, rgb}, {1'b1, FG});
    edit_sel = 3'd0;
    run(4);
    chk("sel_change_on", {in_text, rgb}, {1'b1, SEL});
    edit_sel = 3'd3;
    at(356, 324);
    run(4);
    chk("sel_none", {in_text, rgb}, {1'b1, FG});
    video_on = 1'b0;
    run(3);
    chk("blank", {in_text, rgb}, 13'h0);
    video_on = 1'b1;

    edit_sel = 3'd1;
    run(1);
    for (int t = 1; t <= BF; t++) tick_hold();
    chk("off_phase", {in_text, rgb}, {1'b1, 12'h000});
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(3);
    chk("post_reset", {in_text, rgb}, {1'b1, SEL});

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      video_on   = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) fields_bcd = 24'($urandom);
      if ($urandom_range(0, 199) == 0) edit_on = ~edit_on;
      if ($urandom_range(0, 149) == 0) edit_sel = 3'($urandom_range(0, 7));
      at($urandom_range(180, 580), $urandom_range(310, 395));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_field_renderer.md
# bcd_field_renderer

Parametrised VGA text-overlay renderer for `NUM_FIELDS` two-digit BCD fields (e.g. HH:MM:SS timer or clock) at a configurable origin and integer power-of-two scale. Sits between the time-keeping/programming logic and the RGB multiplexer of the VGA path. It has the following features:

- An internal 8x16 digit font.
- A frame-synchronous snapshot of the displayed values to prevent tearing.
- A 3-stage pixel pipeline.
- Blink highlighting of the field under edit.

## Interface
Parameters:
- `NUM_FIELDS`, default 3: number of two-digit fields, 1..8.
- `X0`, default 192: x of left edge of field 0.
- `Y0`, default 320: y of top edge of all fields.
- `SCALE_SH`, default 2: each font pixel is a 2^SCALE_SH square. Glyph size is W = 8<<SCALE_SH by H = 16<<SCALE_SH.
- `FIELD_GAP`, default 64: horizontal pixels between fields. Field pitch P = 2W + FIELD_GAP.
- `FG_COLOR`, default 12'h0FF: normal digit colour.
- `SEL_COLOR`, default 12'hF00: colour of the field under edit.
- `BLINK_FRAMES`, default 30: frames per blink half-period, ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `video_on`  in  1  active display area.
- `frame_tick`  in  1  one-cycle pulse per frame (end of visible area).
- `pix_x`  in  10  current pixel column.
- `pix_y`  in  10  current pixel row.
- `fields_bcd`  in  8*NUM_FIELDS  field k at bits [8k+7:8k]. Field 0 is leftmost. High nibble is the left digit.
- `edit_on`  in  1  programming mode active.
- `edit_sel`  in  3  index of the field under edit. Values ≥ NUM_FIELDS select none.
- `rgb`  out  12  pixel colour.
- `in_text`  out  1  pixel lies inside any digit box. Aligned with `rgb`.

## Operation
- Snapshot register: loads `fields_bcd` on any cycle with `frame_tick`=1. Rendering uses only the snapshot. Reset clears it, so the display shows "00" in every field.
- Hit test for field k: X0+kP ≤ pix_x ≤ X0+kP+2W−1 and Y0 ≤ pix_y ≤ Y0+H−1. Comparisons use 11-bit unsigned arithmetic with no wrap, so pix_x < X0 never hits.
- Offsets:
  - dx = pix_x − (X0+kP), dy = pix_y − Y0.
  - digit = dx>>(SCALE_SH+3), where 0 selects the high nibble.
  - col = (dx>>SCALE_SH)&7.
  - row = dy>>SCALE_SH, range 0..15.
- Font ROM: 10 glyphs x 16 rows x 8 bits. Col 0 maps to bit 7.
  - Rows 0 and 15 of every glyph are all-zero.
  - Nibbles 10..15 select a blank (all-zero) glyph.
- Colour:
  - Not in a box: 0.
  - Font bit 0: 0.
  - Font bit 1, field not selected: FG_COLOR.
  - Font bit 1, field selected (edit_on=1 and edit_sel=k): SEL_COLOR while blink_phase=1, and 0 while blink_phase=0.
- `video_on`=0 in stage 1 forces rgb=0 and in_text=0 for that pixel.
- Blink FSM, with states ON (blink_phase=1) and OFF (blink_phase=0):
  - A frame counter runs 0..BLINK_FRAMES−1 on `frame_tick` while edit_on=1.
  - On terminal count, the counter wraps to 0 and the state toggles ON↔OFF.
  - edit_on=0, or any change of `edit_sel`, forces ON and counter=0 on the next cycle. This makes a newly selected field visible immediately.
- Reset values: rgb=0, in_text=0, snapshot=0, blink state ON, counter=0, all pipeline registers 0.
- Reset asserted mid-frame or mid-blink: all of the above take their reset values on the next edge, with no partial output.

## Timing
- The block samples every clk. There is no pixel-enable; coordinates held for several clocks produce stable output.
- Pipeline latency is 3 cycles from `pix_x`/`pix_y`/`video_on`/`edit_*` to `rgb`/`in_text`:
  - S1: hit, digit select, nibble, row, col, video_on.
  - S2: registered ROM row read, with col and colour-select carried alongside.
  - S3: bit select and colour, registered outputs.
- A snapshot update takes effect for pixels sampled from the cycle after `frame_tick`.
- Blink toggles on the cycle after the BLINK_FRAMES-th `frame_tick` of the current half-period.
- `frame_tick` coincident with a change of `edit_sel`: the edit_sel reset wins, giving counter=0 and state ON.

## Test plan
1. Reset and default display: hold reset 2 cycles -> rgb=0, in_text=0. Release with fields_bcd=24'h563412 and no frame_tick -> field 0 renders "00" (lit pixels 12'h0FF).
2. Snapshot and latency:
   - Pulse frame_tick, then drive a lit pixel of digit '1' in field 0 -> rgb=12'h0FF exactly 3 cycles later.
   - Change fields_bcd without a tick -> output unchanged.
3. Boundaries (y=330, defaults) -> expected in_text:
   - x=191 -> 0; x=192 -> 1; x=255 -> 1; x=256 -> 0; x=320 -> 1; x=511 -> 1; x=512 -> 0.
   - x=200, y=319 -> 0; y=383 -> 1; y=384 -> 0.
   - Font rows 0/15 -> in_text=1, rgb=0.
4. Invalid BCD: snapshot field 1 = 8'hA7 -> every pixel of its left box gives in_text=1, rgb=0. Right digit '7' renders normally.
5. Edit blink (BLINK_FRAMES=30):
   - edit_on=1, edit_sel=1 -> field 1 lit pixels are 12'hF00 for 30 ticks, then 0 for 30 ticks, then 12'hF00. Field 0 stays 12'h0FF.
   - edit_sel=3 -> no highlight.
   - Changing edit_sel mid-OFF -> ON on the next cycle.
6. Blanking and reset mid-operation:
   - video_on=0 over a lit pixel -> rgb=0, in_text=0.
   - Reset during the OFF phase -> state ON, snapshot 0, outputs 0 on the next cycle.
